// File: rtl/mdio_pkg.sv
// Purpose: shared states, frame constants and frame builder for the clause-22 MDIO master.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package mdio_pkg;

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, END} state_t;

  localparam logic [1:0] ST    = 2'b01;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] OP_RD = 2'b10;

  localparam int HDR_BITS  = 14;
  localparam int TA_BITS   = 2;
  localparam int DATA_BITS = 16;

  // Everything the master may drive after the preamble, MSB first.
  // The TA/data fields are only put on the wire for writes.
  function automatic logic [31:0] build_frame(input logic        wr,
                                              input logic [4:0]  phy_addr,
                                              input logic [4:0]  reg_addr,
                                              input logic [15:0] wdata);
    return {ST, (wr ? OP_WR : OP_RD), phy_addr, reg_addr, 2'b10, wdata};
  endfunction

endpackage

// File: rtl/mdio_clk_div.sv
// Purpose: MDC generator; toggles mdc every CLK_DIV_HALF enabled cycles, flags the toggling cycles.
// Latency: first rise CLK_DIV_HALF cycles after en goes high; rise/fall are combinational pre-edge strobes.
// Backpressure: none; dropping en clears the divider and forces mdc low on the next edge.
module mdio_clk_div #(
  parameter int CLK_DIV_HALF = 10
) (
  input  logic clk_clk,
  input  logic reset_reset,
  input  logic en,
  output logic mdc,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV_HALF > 1) ? $clog2(CLK_DIV_HALF) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV_HALF - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  // rise/fall mark the cycle whose closing edge moves mdc 0->1 / 1->0
  assign wrap = en && (cnt == TOP);
  assign rise = wrap && !mdc;
  assign fall = wrap &&  mdc;

  // Half-period counter; idle holds it at zero so every frame starts with a full low half
  always_ff @(posedge clk_clk) begin
    if (reset_reset || !en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master_ctrl.sv
// Purpose: clause-22 MDIO master; one read/write command at a time, 64-bit frame on MDC/MDIO (MDIO_PREAMBLE_SUPPRESS_EN adds cmd_no_pre).
// Latency: rsp_valid pulses 65*2*CLK_DIV_HALF clk after acceptance (33*2*CLK_DIV_HALF with preamble skipped).
// Backpressure: cmd_ready high only while idle; command inputs are ignored for the whole frame.
module mdio_master_ctrl
  import mdio_pkg::*;
#(
  parameter int CLK_DIV_HALF = 10,
  parameter int PRE_LEN      = 32
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  input  logic        cmd_no_pre,
`endif
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdio_mdc,
  input  logic        mdio_mdio_in,
  output logic        mdio_mdio_out,
  output logic        mdio_mdio_oen
);

  state_t      state;
  logic [7:0]  bit_cnt;
  logic [31:0] sr;
  logic [31:0] frame;
  logic [15:0] rd_sh;
  logic        is_wr;
  logic        ta_err;
  logic        no_pre;
  logic        mdc_rise;
  logic        mdc_fall;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  assign no_pre = cmd_no_pre;
`else
  assign no_pre = 1'b0;
`endif

  assign frame = build_frame(cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata);

  mdio_clk_div #(
    .CLK_DIV_HALF (CLK_DIV_HALF)
  ) u_clk_div (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .en          (state != IDLE),
    .mdc         (mdio_mdc),
    .rise        (mdc_rise),
    .fall        (mdc_fall)
  );

  // Frame sequencer: drives MDIO on MDC falls, samples on MDC rises, bit_cnt counts down per MDC cycle
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      sr            <= '0;
      rd_sh         <= '0;
      is_wr         <= 1'b0;
      ta_err        <= 1'b0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      mdio_mdio_out <= 1'b1;
      mdio_mdio_oen <= 1'b1;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            is_wr         <= cmd_write;
            cmd_ready     <= 1'b0;
            mdio_mdio_oen <= 1'b0;
            if (no_pre) begin
              // First header bit goes out immediately
              state         <= HDR;
              bit_cnt       <= 8'(HDR_BITS - 1);
              mdio_mdio_out <= frame[31];
              sr            <= {frame[30:0], 1'b0};
            end else begin
              state         <= PRE;
              bit_cnt       <= 8'(PRE_LEN - 1);
              mdio_mdio_out <= 1'b1;
              sr            <= frame;
            end
          end
        end

        PRE: begin
          if (mdc_fall) begin
            if (bit_cnt == '0) begin
              state         <= HDR;
              bit_cnt       <= 8'(HDR_BITS - 1);
              mdio_mdio_out <= sr[31];
              sr            <= {sr[30:0], 1'b0};
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end

        HDR: begin
          if (mdc_fall) begin
            sr <= {sr[30:0], 1'b0};
            if (bit_cnt == '0) begin
              // Reads release the line for the PHY's turnaround
              state         <= TA;
              bit_cnt       <= 8'(TA_BITS - 1);
              mdio_mdio_oen <= !is_wr;
              mdio_mdio_out <= is_wr ? sr[31] : 1'b1;
            end else begin
              bit_cnt       <= bit_cnt - 1'b1;
              mdio_mdio_out <= sr[31];
            end
          end
        end

        TA: begin
          // A PHY that is present pulls the second TA bit low
          if (mdc_rise && bit_cnt == '0) begin
            ta_err <= mdio_mdio_in;
          end
          if (mdc_fall) begin
            sr            <= {sr[30:0], 1'b0};
            mdio_mdio_out <= is_wr ? sr[31] : 1'b1;
            if (bit_cnt == '0) begin
              state   <= DATA;
              bit_cnt <= 8'(DATA_BITS - 1);
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end

        DATA: begin
          if (mdc_rise) begin
            rd_sh <= {rd_sh[14:0], mdio_mdio_in};
          end
          if (mdc_fall) begin
            if (bit_cnt == '0) begin
              state         <= END;
              mdio_mdio_out <= 1'b1;
              mdio_mdio_oen <= 1'b1;
            end else begin
              bit_cnt       <= bit_cnt - 1'b1;
              sr            <= {sr[30:0], 1'b0};
              mdio_mdio_out <= is_wr ? sr[31] : 1'b1;
            end
          end
        end

        END: begin
          if (mdc_fall) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= is_wr ? 16'h0000 : rd_sh;
            rsp_err   <= !is_wr && ta_err;
          end
        end

        default: begin
          state         <= IDLE;
          cmd_ready     <= 1'b1;
          mdio_mdio_out <= 1'b1;
          mdio_mdio_oen <= 1'b1;
        end
      endcase
    end
  end

endmodule
